pipe_mdu_ctrl: RTL and testbench
================================

Name: pipe_mdu_ctrl

Overview:
Sequencer and interlock for an iterative multiply/divide unit that sits beside the EXE-stage ALU of the 5-stage MIPS32 pipeline.
- Accepts mult/multu/div/divu from EXE, runs a 32-step shift-add / restoring-divide loop, and writes HI/LO.
- Handles mthi/mtlo writes.
- Stalls the ID stage when an instruction that needs HI/LO or the unit arrives while an operation is in flight.

Parameters:
DW, 32, operand/HI/LO width (only 32 supported; log2 sizing of the step counter follows from it)

Ports:
clock  in  1  pipeline clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
estart  in  1  EXE holds a valid mult/multu/div/divu this cycle
eop  in  2  00 mult, 01 multu, 10 div, 11 divu
ea  in  DW  rs operand (multiplicand/dividend)
eb  in  DW  rt operand (multiplier/divisor)
ewhi  in  1  EXE holds mthi
ewlo  in  1  EXE holds mtlo
ewdata  in  DW  data for mthi/mtlo
dmdu_use  in  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/div
mdu_busy  out  1  operation in flight
mdu_stall  out  1  hold PC and IF/ID, bubble into EXE
mdu_done  out  1  one-cycle pulse when HI/LO updated by an operation
hi  out  DW  HI register
lo  out  DW  LO register

Behaviour:
- Reset (async, any state): state=IDLE, count=0, hi=lo=0, mdu_busy=mdu_done=mdu_stall=0. Reset mid-operation abandons the result.
- States and transitions:
  - IDLE: on estart, latch |ea|, |eb|, result signs and op; count=0; go to CALC.
  - CALC: one iteration per cycle, count 0..31; at count==31 go to SIGN.
  - SIGN: apply sign correction; write hi/lo; go to IDLE.
- Timing: estart sampled at edge T0. CALC occupies T1..T32, SIGN occupies T33. New hi/lo are visible from T34. mdu_done is high during T34 only. mdu_busy = (state != IDLE), i.e. high T1..T33.
- mdu_stall = mdu_busy & dmdu_use. It is combinational and released in the same cycle busy drops.
- Multiply: 64-bit product of magnitudes; negate if the signs differ (mult only). hi = upper 32 bits, lo = lower 32 bits.
- Divide: restoring algorithm on magnitudes.
  - div: quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - lo = quotient, hi = remainder.
- Divide by zero (div and divu): lo = 0xFFFFFFFF, hi = ea. No exception. Full 34-cycle latency still applies.
- Signed overflow 0x80000000 / -1: lo = 0x80000000, hi = 0.
- mthi/mtlo in IDLE: hi or lo = ewdata at that edge. ewhi and ewlo together write both.
- Conflicts and ignored inputs:
  - estart together with ewhi/ewlo in IDLE: estart wins, the writes are ignored.
  - estart, ewhi and ewlo are ignored while busy; the interlock guarantees they do not occur.
- hi/lo hold their value throughout CALC/SIGN. mfhi during busy is prevented by mdu_stall.

Decomposition:
- Shared package pipe_mdu_pkg holds:
  - op encodings MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11
  - state encodings IDLE/CALC/SIGN
  - MDU_STEPS=32
- One natural sub-module, mdu_iter: the combinational single-step datapath (add-shift for multiply, trial-subtract-shift for divide on a 64-bit accumulator).
- pipe_mdu_ctrl owns the FSM, counter, operand/sign latches, HI/LO and the interlock.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, visible at T34, mdu_done pulse at T34, mdu_busy high exactly T1..T33.
- mult -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000/-1 -> lo=0x80000000, hi=0.
- divu 100/0 -> lo=0xFFFFFFFF, hi=100; div 5/0 -> lo=0xFFFFFFFF, hi=5.
- Interlock: start divu, hold dmdu_use=1 from T1 -> mdu_stall high T1..T33, low at T34; dmdu_use=1 with mdu_busy=0 -> stall 0.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 in IDLE -> hi/lo updated next edge; estart with ewhi in the same cycle -> the write is ignored and the operation result lands.
- Assert reset at T10 of a multiply -> all outputs 0 immediately. A new multu 2x3 after release -> lo=6, hi=0 at T34.

Source files
------------

// File: rtl/pipe_mdu_pkg.sv
// Shared encodings for the EXE-side multiply/divide sequencer.
// Op codes mirror the eop field driven by the EXE stage.
package pipe_mdu_pkg;

   localparam int MDU_DW    = 32;
   localparam int MDU_STEPS = 32;

   localparam logic [1:0] MDU_MULT  = 2'b00;
   localparam logic [1:0] MDU_MULTU = 2'b01;
   localparam logic [1:0] MDU_DIV   = 2'b10;
   localparam logic [1:0] MDU_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2
   } mdu_state_t;

   // Two's-complement magnitude when neg is set, passthrough otherwise.
   function automatic logic [MDU_DW-1:0] mdu_mag(input logic [MDU_DW-1:0] v, input logic neg);
      return neg ? (~v + MDU_DW'(1)) : v;
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// One iteration of the MDU loop on a 2*DW accumulator: shift-add multiply
// (multiplier in the low half, shifted out LSB first) or restoring divide step.
module mdu_iter #(
   parameter int DW = 32
) (
   input  logic            is_div,
   input  logic [2*DW-1:0] acc_in,
   input  logic [DW-1:0]   opnd,
   output logic [2*DW-1:0] acc_out
);

   logic [DW:0] sum;
   logic [DW:0] trial;

   always_comb begin
      sum   = {1'b0, acc_in[2*DW-1:DW]} + {1'b0, opnd};
      // Partial remainder shifted left by one, minus the divisor; bit DW is the borrow.
      trial = acc_in[2*DW-1:DW-1] - {1'b0, opnd};
      if (is_div) begin
         if (!trial[DW])
            acc_out = {trial[DW-1:0], acc_in[DW-2:0], 1'b1};
         else
            acc_out = {acc_in[2*DW-2:0], 1'b0};
      end else if (acc_in[0]) begin
         acc_out = {sum, acc_in[DW-1:1]};
      end else begin
         acc_out = {1'b0, acc_in[2*DW-1:1]};
      end
   end

endmodule

// File: rtl/pipe_mdu_ctrl.sv
// Iterative MDU sequencer: 32 CALC cycles plus one SIGN cycle, HI/LO visible
// two edges after the last step; stalls ID while busy and ID needs the unit.
module pipe_mdu_ctrl
   import pipe_mdu_pkg::*;
#(
   parameter int DW = MDU_DW
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          estart,
   input  logic [1:0]    eop,
   input  logic [DW-1:0] ea,
   input  logic [DW-1:0] eb,
   input  logic          ewhi,
   input  logic          ewlo,
   input  logic [DW-1:0] ewdata,
   input  logic          dmdu_use,
   output logic          mdu_busy,
   output logic          mdu_stall,
   output logic          mdu_done,
   output logic [DW-1:0] hi,
   output logic [DW-1:0] lo
);

   localparam int CW = $clog2(MDU_STEPS);
   localparam int AW = 2 * DW;

   mdu_state_t    state, state_nxt;
   logic [CW-1:0] count;
   logic [AW-1:0] acc, acc_step, prod_fix;
   logic [DW-1:0] opnd, a_mag;
   logic          op_div, neg_res, neg_a, div_zero;

   logic          start_mul, start_signed;
   logic [DW-1:0] ea_mag, eb_mag;
   logic [DW-1:0] hi_res, lo_res;

   mdu_iter #(.DW(DW)) u_iter (
      .is_div  (op_div),
      .acc_in  (acc),
      .opnd    (opnd),
      .acc_out (acc_step)
   );

   always_comb begin
      start_mul    = (eop == MDU_MULT) || (eop == MDU_MULTU);
      start_signed = (eop == MDU_MULT) || (eop == MDU_DIV);
      ea_mag       = mdu_mag(ea, start_signed & ea[DW-1]);
      eb_mag       = mdu_mag(eb, start_signed & eb[DW-1]);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (estart) state_nxt = CALC;
         CALC:    if (count == CW'(MDU_STEPS - 1)) state_nxt = SIGN;
         SIGN:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Multiply seeds the low half with the multiplier; divide seeds it with the dividend.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count    <= '0;
         acc      <= '0;
         opnd     <= '0;
         a_mag    <= '0;
         op_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_a    <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (estart) begin
                  count    <= '0;
                  op_div   <= !start_mul;
                  neg_res  <= start_signed & (ea[DW-1] ^ eb[DW-1]);
                  neg_a    <= start_signed & ea[DW-1];
                  div_zero <= !start_mul && (eb == '0);
                  a_mag    <= ea_mag;
                  if (start_mul) begin
                     acc  <= {{DW{1'b0}}, eb_mag};
                     opnd <= ea_mag;
                  end else begin
                     acc  <= {{DW{1'b0}}, ea_mag};
                     opnd <= eb_mag;
                  end
               end
            end
            CALC: begin
               acc   <= acc_step;
               count <= count + CW'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      prod_fix = neg_res ? (~acc + AW'(1)) : acc;
      if (!op_div) begin
         hi_res = prod_fix[AW-1:DW];
         lo_res = prod_fix[DW-1:0];
      end else if (div_zero) begin
         // Divide by zero returns the original dividend in HI.
         hi_res = mdu_mag(a_mag, neg_a);
         lo_res = '1;
      end else begin
         hi_res = mdu_mag(acc[AW-1:DW], neg_a);
         lo_res = mdu_mag(acc[DW-1:0], neg_res);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hi       <= '0;
         lo       <= '0;
         mdu_done <= 1'b0;
      end else begin
         mdu_done <= (state == SIGN);
         if (state == SIGN) begin
            hi <= hi_res;
            lo <= lo_res;
         end else if (state == IDLE && !estart) begin
            if (ewhi) hi <= ewdata;
            if (ewlo) lo <= ewdata;
         end
      end
   end

   assign mdu_busy  = (state != IDLE);
   assign mdu_stall = mdu_busy & dmdu_use;

endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// Scoreboard bench for pipe_mdu_ctrl: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_pipe_mdu_ctrl;

   logic        clock, reset, estart, ewhi, ewlo, dmdu_use;
   logic [1:0]  eop;
   logic [31:0] ea, eb, ewdata;
   logic        mdu_busy, mdu_stall, mdu_done;
   logic [31:0] hi, lo;

   pipe_mdu_ctrl #(.DW(32)) dut (
      .clock(clock), .reset(reset), .estart(estart), .eop(eop), .ea(ea), .eb(eb),
      .ewhi(ewhi), .ewlo(ewlo), .ewdata(ewdata), .dmdu_use(dmdu_use),
      .mdu_busy(mdu_busy), .mdu_stall(mdu_stall), .mdu_done(mdu_done), .hi(hi), .lo(lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int          due;
      logic [31:0] hi;
      logic [31:0] lo;
      bit          is_op;
   } exp_t;

   exp_t        op_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          busy_from = 1;
   int          busy_to   = 0;
   logic [31:0] arch_hi = '0, arch_lo = '0;
   logic [31:0] sm_hi = '0, sm_lo = '0;
   logic        exp_busy;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: plain 64-bit and signed integer arithmetic.
   function automatic logic [63:0] ref_mdu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      int sa, sb, q, r;
      sa = a;
      sb = b;
      case (op)
         2'b00: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         2'b01: p = {32'd0, a} * {32'd0, b};
         2'b11: p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r, q};
            end
         end
      endcase
      return p;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   // Monitor: one look per cycle, 1 time unit after the rising edge.
   always @(posedge clock) begin
      cyc = cyc + 1;
      #1;
      if (!reset) begin
         exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
         if (op_q.size() > 0 && !op_q[0].is_op && op_q[0].due == cyc) begin
            arch_hi = op_q[0].hi;
            arch_lo = op_q[0].lo;
            void'(op_q.pop_front());
         end
         if (mdu_done) begin
            if (op_q.size() > 0 && op_q[0].is_op) begin
               chk("done_cycle", 32'(cyc), 32'(op_q[0].due));
               arch_hi = op_q[0].hi;
               arch_lo = op_q[0].lo;
               void'(op_q.pop_front());
            end else begin
               n_tests++;
               n_fail++;
               $display("FAIL spurious_done at cycle %0d: got 1 expected 0", cyc);
            end
         end else if (op_q.size() > 0 && op_q[0].due < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_update due cycle %0d: got nothing by cycle %0d", op_q[0].due, cyc);
            void'(op_q.pop_front());
         end
         chk("hi", hi, arch_hi);
         chk("lo", lo, arch_lo);
         chk("busy", 32'(mdu_busy), 32'(exp_busy));
         chk("stall", 32'(mdu_stall), 32'(exp_busy & dmdu_use));
      end
   end

   task automatic issue_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic wr_too, input logic use_hold);
      exp_t e;
      logic [63:0] r;
      @(negedge clock);
      r        = ref_mdu(op, a, b);
      e.due    = cyc + 34;
      e.hi     = r[63:32];
      e.lo     = r[31:0];
      e.is_op  = 1'b1;
      op_q.push_back(e);
      busy_from = cyc + 1;
      busy_to   = cyc + 33;
      sm_hi = e.hi;
      sm_lo = e.lo;
      estart = 1'b1; eop = op; ea = a; eb = b;
      ewhi = wr_too; ewlo = wr_too; ewdata = $urandom;
      dmdu_use = use_hold ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clock);
      estart = 1'b0; ewhi = 1'b0; ewlo = 1'b0;
      ea = $urandom; eb = $urandom;
      repeat (33) begin
         dmdu_use = use_hold ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge clock);
      end
   endtask

   task automatic issue_wr(input logic whi, input logic wlo, input logic [31:0] d);
      exp_t e;
      @(negedge clock);
      if (whi) sm_hi = d;
      if (wlo) sm_lo = d;
      e.due   = cyc + 1;
      e.hi    = sm_hi;
      e.lo    = sm_lo;
      e.is_op = 1'b0;
      op_q.push_back(e);
      ewhi = whi; ewlo = wlo; ewdata = d;
      dmdu_use = 1'($urandom_range(0, 1));
      @(negedge clock);
      ewhi = 1'b0; ewlo = 1'b0; ewdata = $urandom;
   endtask

   initial begin
      reset = 1'b1; estart = 1'b0; eop = 2'b00; ea = '0; eb = '0;
      ewhi = 1'b0; ewlo = 1'b0; ewdata = '0; dmdu_use = 1'b1;
      repeat (2) @(negedge clock);
      chk("rst_busy", 32'(mdu_busy), 32'd0);
      chk("rst_stall", 32'(mdu_stall), 32'd0);
      chk("rst_done", 32'(mdu_done), 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      reset = 1'b0;
      dmdu_use = 1'b0;

      issue_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      issue_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
      issue_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      issue_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      issue_op(2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
      issue_op(2'b10, 32'd5, 32'd0, 1'b0, 1'b0);
      issue_wr(1'b1, 1'b0, 32'h1234_5678);
      issue_wr(1'b0, 1'b1, 32'h9ABC_DEF0);
      issue_wr(1'b1, 1'b1, 32'hA5A5_0F0F);
      // estart with mthi/mtlo in the same cycle: writes must be dropped.
      issue_op(2'b01, 32'h10, 32'h20, 1'b1, 1'b0);
      issue_op(2'b11, 32'd1000, 32'd7, 1'b0, 1'b1);
      repeat (3) @(negedge clock);
      dmdu_use = 1'b0;

      // Abort a multiply partway through with an asynchronous reset.
      @(negedge clock);
      busy_from = cyc + 1;
      busy_to   = cyc + 33;
      estart = 1'b1; eop = 2'b00; ea = 32'h0001_2345; eb = 32'hFFFF_0003;
      @(negedge clock);
      estart = 1'b0;
      repeat (8) @(negedge clock);
      dmdu_use = 1'b1;
      reset = 1'b1;
      op_q.delete();
      busy_from = 1; busy_to = 0;
      arch_hi = '0; arch_lo = '0; sm_hi = '0; sm_lo = '0;
      #1;
      chk("midrst_busy", 32'(mdu_busy), 32'd0);
      chk("midrst_stall", 32'(mdu_stall), 32'd0);
      chk("midrst_done", 32'(mdu_done), 32'd0);
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_lo", lo, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      dmdu_use = 1'b0;
      issue_op(2'b01, 32'd2, 32'd3, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0)
            issue_wr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         else
            issue_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
      end

      repeat (3) @(negedge clock);
      chk("queue_drained", 32'(op_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
